// File: rtl/z_word_serializer.sv
// Word serializer: buffers 5-bit words in a small circular FIFO and sends each
// one as an 8-bit-time frame (start, 5 data bits LSB first, even parity, stop).
module z_word_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [4:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   ser_out,
  output logic                   busy,
  output logic                   frame_done,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] TICK_LAST = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [4:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ser_out_q, ser_out_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  logic [4:0]    mem_q [DEPTH];
  logic [4:0]    head;
  logic          push;
  logic          pop;
  logic          bit_end;

  // Ready depends only on the registered count, so it never loops back to in_valid.
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];
  assign bit_end  = (tick_q == TICK_LAST);

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    pop      = 1'b0;

    if (state_q != IDLE) begin
      tick_d = bit_end ? 8'd0 : tick_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd4) state_d = PARITY;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Chain straight into the next frame when a word is waiting.
        if (bit_end) begin
          if (count_q != '0) pop     = 1'b1;
          else               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d  = START;
      shreg_d  = head;
      parity_d = ^head;
      tick_d   = 8'd0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    ser_out_d    = 1'b1;
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == STOP) && (tick_d == TICK_LAST);
    case (state_d)
      IDLE:    ser_out_d = 1'b1;
      START:   ser_out_d = 1'b0;
      DATA:    ser_out_d = shreg_d[0];
      PARITY:  ser_out_d = parity_d;
      STOP:    ser_out_d = 1'b1;
      default: ser_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      tick_q       <= 8'd0;
      bit_q        <= 3'd0;
      shreg_q      <= 5'd0;
      parity_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ser_out_q    <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      parity_q     <= parity_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ser_out_q    <= ser_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign ser_out    = ser_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_z_word_serializer.sv
// Directed bench for z_word_serializer at default parameters (4 clocks/bit, depth 4).
module tb_z_word_serializer;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       busy;
  logic       frame_done;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  z_word_serializer #(.CLKS_PER_BIT(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_out    (ser_out),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level in cycle k (1..32) of a frame carrying word w.
  function automatic logic exp_ser(input logic [4:0] w, input int k);
    int b;
    b = (k - 1) / 4;
    if (b == 0)      return 1'b0;
    else if (b <= 5) return w[b-1];
    else if (b == 6) return ^w;
    else             return 1'b1;
  endfunction

  task automatic push_word(input logic [4:0] w);
    int waitc;
    waitc    = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("push %b accepted", w);
  endtask

  task automatic verify_frame(input logic [4:0] w, input int first_k);
    for (int k = first_k; k <= 32; k++) begin
      @(posedge clk); #1;
      check($sformatf("ser_%b_k%0d", w, k), 32'(ser_out), 32'(exp_ser(w, k)));
      check($sformatf("busy_%b_k%0d", w, k), 32'(busy), 32'd1);
      check($sformatf("fdone_%b_k%0d", w, k), 32'(frame_done), 32'(k == 32));
    end
    $display("frame %b checked from cycle %0d", w, first_k);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ser"}, 32'(ser_out), 32'd1);
    check({tag, "_fdone"}, 32'(frame_done), 32'd0);
    check({tag, "_count"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    check("rst_ready", 32'(in_ready), 32'd1);
    rstn = 1'b1;

    // Single word 11001: data 1,0,0,1,1, parity 1.
    push_word(5'b11001);
    check("single_count", 32'(fifo_count), 32'd1);
    check("single_ser_pre", 32'(ser_out), 32'd1);
    check("single_busy_pre", 32'(busy), 32'd0);
    verify_frame(5'b11001, 1);
    @(posedge clk); #1;
    check_idle("single_after");

    // Parity zero: 00011.
    push_word(5'b00011);
    verify_frame(5'b00011, 1);
    @(posedge clk); #1;
    check_idle("par0_after");

    // Back-to-back: three words, 96 busy cycles with no gap.
    fork
      begin
        push_word(5'b10101);
        push_word(5'b01110);
        push_word(5'b00001);
      end
      begin
        @(posedge clk); #1;
        verify_frame(5'b10101, 1);
        verify_frame(5'b01110, 1);
        verify_frame(5'b00001, 1);
      end
    join
    @(posedge clk); #1;
    check_idle("b2b_after");

    // Fill: A is in flight, B..E fill the FIFO, F waits for the first pop.
    push_word(5'b00111);
    in_valid = 1'b1;
    in_data  = 5'b10000; @(posedge clk); #1; check("fill_c1", 32'(fifo_count), 32'd1);
    in_data  = 5'b01000; @(posedge clk); #1; check("fill_c2", 32'(fifo_count), 32'd2);
    in_data  = 5'b00100; @(posedge clk); #1; check("fill_c3", 32'(fifo_count), 32'd3);
    in_data  = 5'b00010; @(posedge clk); #1; check("fill_c4", 32'(fifo_count), 32'd4);
    check("fill_ready_low", 32'(in_ready), 32'd0);
    in_data  = 5'b11110;
    repeat (28) @(posedge clk);
    #1;
    check("fill_hold_count", 32'(fifo_count), 32'd4);
    check("fill_hold_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("fill_pop_count", 32'(fifo_count), 32'd3);
    check("fill_pop_ready", 32'(in_ready), 32'd1);
    check("fill_pop_ser", 32'(ser_out), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("fill_push5_count", 32'(fifo_count), 32'd4);
    verify_frame(5'b10000, 3);
    verify_frame(5'b01000, 1);
    verify_frame(5'b00100, 1);
    verify_frame(5'b00010, 1);
    verify_frame(5'b11110, 1);
    @(posedge clk); #1;
    check_idle("fill_after");

    // Simultaneous push and pop on the STOP-expiry edge.
    push_word(5'b01010);
    fork
      begin
        push_word(5'b11000);
        push_word(5'b00110);
      end
      verify_frame(5'b01010, 1);
    join
    check("sim_count_pre", 32'(fifo_count), 32'd2);
    in_data  = 5'b10011;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("sim_count", 32'(fifo_count), 32'd2);
    check("sim_start", 32'(ser_out), 32'd0);
    verify_frame(5'b11000, 2);
    verify_frame(5'b00110, 1);
    verify_frame(5'b10011, 1);
    @(posedge clk); #1;
    check_idle("sim_after");

    // Reset during data bit 2 with two words queued.
    push_word(5'b11011);
    fork
      begin
        push_word(5'b00101);
        push_word(5'b01001);
      end
      begin
        repeat (14) begin
          @(posedge clk); #1;
        end
      end
    join
    check("rstmid_ser_pre", 32'(ser_out), 32'd0);
    check("rstmid_count_pre", 32'(fifo_count), 32'd2);
    #2;
    rstn = 1'b0;
    #1;
    check_idle("rstmid_async");
    check("rstmid_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid_idle_busy_%0d", i), 32'(busy), 32'd0);
      check($sformatf("rstmid_idle_ser_%0d", i), 32'(ser_out), 32'd1);
    end
    check("rstmid_idle_count", 32'(fifo_count), 32'd0);

    // First push after reset release lands on the first edge.
    rstn     = 1'b0;
    in_data  = 5'b10110;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rel_count", 32'(fifo_count), 32'd1);
    verify_frame(5'b10110, 1);
    @(posedge clk); #1;
    check_idle("rel_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
